// File: rtl/serial_pattern_source_pkg.sv
// Shared definitions for the serial pattern source and its downstream detectors:
// FSM state encodings and the default word width.
package serial_pattern_source_pkg;

   localparam logic SER_IDLE      = 1'b0;
   localparam logic SER_SHIFT     = 1'b1;
   localparam int   SER_DEF_WIDTH = 8;

endpackage

// File: rtl/serial_pattern_source.sv
// Parallel-in/serial-out bit feeder: takes WIDTH-bit words over valid/ready and
// presents them one bit per clock on x, back-to-back with no gap, stallable by hold.
module serial_pattern_source
   import serial_pattern_source_pkg::*;
#(
   parameter int   WIDTH     = SER_DEF_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             hold,
   output logic             x,
   output logic             x_valid,
   output logic             done
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nxt;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             done_q, done_d;
   logic             last_bit, accept;

   assign last_bit  = (state_q == SER_SHIFT) && (count_q == LAST);
   assign din_ready = (state_q == SER_IDLE) || (last_bit && !hold);
   assign accept    = din_valid && din_ready;
   // The bit on x always sits at the outgoing end of shreg_q.
   assign shreg_nxt = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shreg_d   = shreg_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      done_d    = done_q;
      if (accept) begin
         state_d   = SER_SHIFT;
         count_d   = '0;
         shreg_d   = din;
         x_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
         x_valid_d = 1'b1;
         done_d    = (WIDTH == 1);
      end else if (state_q == SER_SHIFT && !hold) begin
         if (last_bit) begin
            state_d   = SER_IDLE;
            count_d   = '0;
            x_d       = IDLE_BIT;
            x_valid_d = 1'b0;
            done_d    = 1'b0;
         end else begin
            count_d = count_q + CW'(1);
            shreg_d = shreg_nxt;
            x_d     = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];
            done_d  = (count_d == LAST);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SER_IDLE;
         count_q   <= '0;
         shreg_q   <= '0;
         x_q       <= IDLE_BIT;
         x_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         shreg_q   <= shreg_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         done_q    <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: three instances (MSB-first, LSB-first, WIDTH=1)
// share one stimulus stream and are checked every cycle against a bit-queue model.
module tb_serial_pattern_source;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       hold = 1'b0;
   logic [2:0] xo, xv, dn, rdy;

   always #5 clk = ~clk;

   serial_pattern_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
      .hold(hold), .x(xo[0]), .x_valid(xv[0]), .done(dn[0]));
   serial_pattern_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
      .hold(hold), .x(xo[1]), .x_valid(xv[1]), .done(dn[1]));
   serial_pattern_source #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
      .clk(clk), .reset(reset), .din(din[0:0]), .din_valid(din_valid), .din_ready(rdy[2]),
      .hold(hold), .x(xo[2]), .x_valid(xv[2]), .done(dn[2]));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
      end
   endtask

   // Model: per instance, the list of bits still to be shown on x (head = bit 0).
   logic [63:0] mb [3];
   int          mn [3] = '{0, 0, 0};
   int          mw [3] = '{8, 8, 1};
   bit          mmsb [3] = '{1'b1, 1'b0, 1'b1};

   always @(posedge clk or posedge reset) begin
      bit r;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            mn[i] = 0;
            mb[i] = '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            r = (mn[i] == 0) || (mn[i] == 1 && !hold);
            if (mn[i] > 0 && !hold) begin
               mb[i] = mb[i] >> 1;
               mn[i]--;
            end
            if (din_valid && r) begin
               for (int k = 0; k < mw[i]; k++)
                  mb[i][mn[i]+k] = mmsb[i] ? din[mw[i]-1-k] : din[k];
               mn[i] += mw[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("inst%0d x", i),       32'(xo[i]),  32'((mn[i] > 0) ? mb[i][0] : 1'b0));
         chk($sformatf("inst%0d x_valid", i), 32'(xv[i]),  32'(mn[i] > 0));
         chk($sformatf("inst%0d done", i),    32'(dn[i]),  32'(mn[i] == 1));
         chk($sformatf("inst%0d ready", i),   32'(rdy[i]), 32'((mn[i] == 0) || (mn[i] == 1 && !hold)));
      end
   end

   // Capture of every valid bit seen on x, for the literal per-test expectations.
   logic [31:0] cap [3];
   int          nv [3];
   int          nd [3];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (xv[i]) begin
            cap[i] = {cap[i][30:0], xo[i]};
            nv[i]++;
         end
         if (dn[i]) nd[i]++;
      end
   end

   task automatic clr();
      for (int i = 0; i < 3; i++) begin
         cap[i] = '0;
         nv[i]  = 0;
         nd[i]  = 0;
      end
   endtask

   task automatic send(input logic [7:0] w);
      int t = 0;
      din       = w;
      din_valid = 1'b1;
      @(negedge clk);
      while (!rdy[0] && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) chk("send timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 din_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (xv != 3'b000 && t < 60) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 60) chk("idle timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("reset x",       32'(xo),  32'h0);
      chk("reset x_valid", 32'(xv),  32'h0);
      chk("reset done",    32'(dn),  32'h0);
      chk("reset ready",   32'(rdy), 32'h7);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // single word, both bit orders, and WIDTH=1 taking din[0]
      clr();
      send(8'hB6);
      wait_idle();
      chk("t1 msb bits", cap[0], 32'hB6);
      chk("t1 msb nvalid", 32'(nv[0]), 32'd8);
      chk("t1 msb ndone", 32'(nd[0]), 32'd1);
      chk("t1 lsb bits", cap[1], 32'h6D);
      chk("t1 w1 nvalid", 32'(nv[2]), 32'd1);
      chk("t1 w1 ndone", 32'(nd[2]), 32'd1);

      // back-to-back words with no gap
      clr();
      send(8'hA5);
      send(8'h3C);
      wait_idle();
      chk("t2 bits", cap[0], 32'hA53C);
      chk("t2 nvalid", 32'(nv[0]), 32'd16);
      chk("t2 ndone", 32'(nd[0]), 32'd2);

      // hold for 3 clocks while the 4th bit is on x
      clr();
      send(8'hF0);
      repeat (3) @(posedge clk);
      #1 hold = 1'b1;
      @(negedge clk);
      chk("t3 w1 ready under hold", 32'(rdy[2]), 32'd1);
      chk("t3 msb ready under hold", 32'(rdy[0]), 32'd0);
      repeat (3) @(posedge clk);
      #1 hold = 1'b0;
      wait_idle();
      chk("t3 bits", cap[0], 32'h7F0);
      chk("t3 nvalid", 32'(nv[0]), 32'd11);
      chk("t3 ndone", 32'(nd[0]), 32'd1);

      // LSB-first word, and din_valid mid-word must be ignored
      clr();
      send(8'h01);
      din       = 8'hFF;
      din_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t4 busy ready", 32'(rdy[0]), 32'd0);
      end
      @(posedge clk);
      #1 din_valid = 1'b0;
      wait_idle();
      chk("t4 lsb bits", cap[1], 32'h80);
      chk("t4 lsb nvalid", 32'(nv[1]), 32'd8);
      chk("t4 msb bits", cap[0], 32'h01);
      chk("t4 msb nvalid", 32'(nv[0]), 32'd8);

      // asynchronous reset mid-word, then a fresh word
      clr();
      send(8'hAA);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("t5 async x", 32'(xo[0]), 32'd0);
      chk("t5 async x_valid", 32'(xv[0]), 32'd0);
      chk("t5 async done", 32'(dn[0]), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      clr();
      send(8'h0F);
      wait_idle();
      chk("t5 bits", cap[0], 32'h0F);
      chk("t5 nvalid", 32'(nv[0]), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
